// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and types for the regfile_sb register file slice.
`default_nettype none

package rf_pkg;

  localparam int DW_DEF   = 32;
  localparam int NREG_DEF = 32;
  localparam int ZERO_REG = 0;

  typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t;

endpackage : rf_pkg

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-load bits and the decode-stage stall term.
`default_nettype none

module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_set,
  input  logic [AW-1:0] i_set_addr,
  input  logic          i_clr,
  input  logic [AW-1:0] i_clr_addr,
  input  logic          i_chk_en,
  input  logic [AW-1:0] i_addr_a,
  input  logic [AW-1:0] i_addr_b,
  input  logic [AW-1:0] i_addr_c,
  output logic          o_stall
);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pending_nxt;

  // Set is applied after clear so a new load supersedes a retiring one.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_clr) w_pending_nxt[i_clr_addr] = 1'b0;
    if (i_set) w_pending_nxt[i_set_addr] = 1'b1;
    w_pending_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pending <= '0;
    else          r_pending <= w_pending_nxt;
  end

  assign o_stall = i_chk_en &
                   (r_pending[i_addr_a] | r_pending[i_addr_b] | r_pending[i_addr_c]);

endmodule : rf_scoreboard

`default_nettype wire

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/2W register file with load scoreboard; Rev 1.0.
// Optional same-cycle write-to-read forwarding under macro REGFILE_BYPASS_EN.
`default_nettype none

module regfile_sb
  import rf_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NREG = NREG_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n_regFile,
  input  logic [AW-1:0] rAddr_source,
  input  logic [AW-1:0] rAddr_anotherSource,
  output logic [DW-1:0] regA,
  output logic [DW-1:0] regB,
  input  logic          ctrl_regFile_write,
  input  logic [AW-1:0] rAddr_dest,
  input  logic [DW-1:0] alu_out,
  input  logic          ctrl_memWb_write,
  input  logic [AW-1:0] rAddr_memWb,
  input  logic [DW-1:0] mem_data,
  input  logic          issue_load,
  input  logic [AW-1:0] rAddr_issue,
  input  logic          chk_en,
  output logic          stall,
  output logic          wr_conflict
);

  localparam logic [AW-1:0] c_zero = AW'(ZERO_REG);

  // Asserts immediately, releases two clocks after rst_n_regFile rises.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst_n_regFile) begin
    if (!rst_n_regFile) r_rst_sync <= 2'b00;
    else                r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  logic [DW-1:0] r_mem [NREG];
  logic          r_wr_conflict;
  logic          w_we0;
  logic          w_we1;
  logic          w_conflict;

  assign w_we0      = ctrl_regFile_write && (rAddr_dest != c_zero);
  assign w_conflict = w_we0 && ctrl_memWb_write && (rAddr_memWb == rAddr_dest);
  assign w_we1      = ctrl_memWb_write && (rAddr_memWb != c_zero) && !w_conflict;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      r_wr_conflict <= 1'b0;
    end else begin
      if (w_we0) r_mem[rAddr_dest]  <= alu_out;
      if (w_we1) r_mem[rAddr_memWb] <= mem_data;
      if (w_conflict) r_wr_conflict <= 1'b1;
    end
  end

  assign wr_conflict = r_wr_conflict;

  always_comb begin
    regA = (rAddr_source        == c_zero) ? '0 : r_mem[rAddr_source];
    regB = (rAddr_anotherSource == c_zero) ? '0 : r_mem[rAddr_anotherSource];
`ifdef REGFILE_BYPASS_EN
    // Port 0 is checked last so it overrides port 1 on a shared address.
    if (ctrl_memWb_write && rAddr_memWb != c_zero && rAddr_memWb == rAddr_source)
      regA = mem_data;
    if (ctrl_memWb_write && rAddr_memWb != c_zero && rAddr_memWb == rAddr_anotherSource)
      regB = mem_data;
    if (w_we0 && rAddr_dest == rAddr_source)        regA = alu_out;
    if (w_we0 && rAddr_dest == rAddr_anotherSource) regB = alu_out;
`endif
  end

  rf_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk        (clk),
    .i_rst_n    (w_rst_n),
    .i_set      (issue_load),
    .i_set_addr (rAddr_issue),
    .i_clr      (ctrl_memWb_write),
    .i_clr_addr (rAddr_memWb),
    .i_chk_en   (chk_en),
    .i_addr_a   (rAddr_source),
    .i_addr_b   (rAddr_anotherSource),
    .i_addr_c   (rAddr_issue),
    .o_stall    (stall)
  );

endmodule : regfile_sb

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb.
`default_nettype none

module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] rs = '0, rt = '0, dest = '0, wb_addr = '0, iss_addr = '0;
  logic [DW-1:0] alu = '0, mdata = '0;
  logic          we0 = 1'b0, we1 = 1'b0, ld = 1'b0, chk = 1'b0;
  logic [DW-1:0] regA, regB;
  logic          stall, wr_conflict;

  int checks = 0;
  int errors = 0;

  regfile_sb dut (
    .clk                 (clk),
    .rst_n_regFile       (rst_n),
    .rAddr_source        (rs),
    .rAddr_anotherSource (rt),
    .regA                (regA),
    .regB                (regB),
    .ctrl_regFile_write  (we0),
    .rAddr_dest          (dest),
    .alu_out             (alu),
    .ctrl_memWb_write    (we1),
    .rAddr_memWb         (wb_addr),
    .mem_data            (mdata),
    .issue_load          (ld),
    .rAddr_issue         (iss_addr),
    .chk_en              (chk),
    .stall               (stall),
    .wr_conflict         (wr_conflict)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; ld = 1'b0; chk = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    rs = 5'd5; rt = 5'd31; chk = 1'b1; iss_addr = 5'd7;
    #2;
    checks++;
    if (regA !== 32'h0 || regB !== 32'h0) begin
      errors++; $display("FAIL reset_regs: regA=%h regB=%h expected 0", regA, regB);
    end
    checks++;
    if (stall !== 1'b0 || wr_conflict !== 1'b0) begin
      errors++; $display("FAIL reset_flags: stall=%b wr_conflict=%b expected 0", stall, wr_conflict);
    end
    idle();
  endtask

  task automatic test_write_r0();
    step();
    we0 = 1'b1; dest = 5'd0; alu = 32'hFFFF_FFFF;
    we1 = 1'b1; wb_addr = 5'd0; mdata = 32'hDEAD_BEEF;
    step();
    idle(); rs = 5'd0; rt = 5'd0;
    #2;
    checks++;
    if (regA !== 32'h0 || regB !== 32'h0) begin
      errors++; $display("FAIL write_r0: regA=%h regB=%h expected 0", regA, regB);
    end
    checks++;
    if (wr_conflict !== 1'b0) begin
      errors++; $display("FAIL write_r0_conflict: wr_conflict=%b expected 0", wr_conflict);
    end
  endtask

  task automatic test_dual_write();
    step();
    we0 = 1'b1; dest = 5'd1; alu = 32'h11;
    we1 = 1'b1; wb_addr = 5'd2; mdata = 32'h22;
    step();
    idle(); rs = 5'd1; rt = 5'd2;
    #2;
    checks++;
    if (regA !== 32'h11 || regB !== 32'h22 || wr_conflict !== 1'b0) begin
      errors++; $display("FAIL dual_write_distinct: regA=%h regB=%h conflict=%b expected 11 22 0",
                         regA, regB, wr_conflict);
    end
    step();
    we0 = 1'b1; dest = 5'd3; alu = 32'hA;
    we1 = 1'b1; wb_addr = 5'd3; mdata = 32'hB;
    step();
    idle(); rs = 5'd3;
    #2;
    checks++;
    if (regA !== 32'hA) begin
      errors++; $display("FAIL dual_write_same: regA=%h expected a", regA);
    end
    checks++;
    if (wr_conflict !== 1'b1) begin
      errors++; $display("FAIL conflict_set: wr_conflict=%b expected 1", wr_conflict);
    end
    repeat (3) step();
    checks++;
    if (wr_conflict !== 1'b1) begin
      errors++; $display("FAIL conflict_sticky: wr_conflict=%b expected 1", wr_conflict);
    end
  endtask

  task automatic test_load_hazard();
    step();
    ld = 1'b1; iss_addr = 5'd7; chk = 1'b1; rs = 5'd7; rt = 5'd0;
    #2;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL hazard_before_edge: stall=%b expected 0", stall);
    end
    step();
    ld = 1'b0; iss_addr = 5'd0;
    #2;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL hazard_rs: stall=%b expected 1", stall);
    end
    chk = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL hazard_chk_gate: stall=%b expected 0", stall);
    end
    chk = 1'b1; rs = 5'd1; iss_addr = 5'd7;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL hazard_waw: stall=%b expected 1", stall);
    end
    iss_addr = 5'd0; rs = 5'd7;
    we1 = 1'b1; wb_addr = 5'd7; mdata = 32'h55;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL hazard_same_cycle_clear: stall=%b expected 1", stall);
    end
    step();
    we1 = 1'b0;
    #2;
    checks++;
    if (stall !== 1'b0 || regA !== 32'h55) begin
      errors++; $display("FAIL hazard_release: stall=%b regA=%h expected 0 55", stall, regA);
    end
    idle();
  endtask

  task automatic test_set_clear_collision();
    step();
    ld = 1'b1; iss_addr = 5'd9;
    step();
    we1 = 1'b1; wb_addr = 5'd9; mdata = 32'h99;
    step();
    idle(); iss_addr = 5'd0; chk = 1'b1; rs = 5'd0; rt = 5'd9;
    #2;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL setclr_collision: stall=%b expected 1", stall);
    end
    checks++;
    if (regB !== 32'h99) begin
      errors++; $display("FAIL setclr_data: regB=%h expected 99", regB);
    end
    we1 = 1'b1; wb_addr = 5'd9; mdata = 32'h9A;
    step();
    we1 = 1'b0;
    #2;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL setclr_final_clear: stall=%b expected 0", stall);
    end
    idle();
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp_a, exp_b;
    step();
    we0 = 1'b1; dest = 5'd4; alu = 32'h10;
    step();
    we0 = 1'b1; dest = 5'd4; alu = 32'h77; rs = 5'd4;
    we1 = 1'b1; wb_addr = 5'd6; mdata = 32'h66; rt = 5'd6;
`ifdef REGFILE_BYPASS_EN
    exp_a = 32'h77; exp_b = 32'h66;
`else
    exp_a = 32'h10; exp_b = 32'h0;
`endif
    #2;
    checks++;
    if (regA !== exp_a) begin
      errors++; $display("FAIL bypass_port0_same_cycle: regA=%h expected %h", regA, exp_a);
    end
    checks++;
    if (regB !== exp_b) begin
      errors++; $display("FAIL bypass_port1_same_cycle: regB=%h expected %h", regB, exp_b);
    end
    step();
    idle();
    #2;
    checks++;
    if (regA !== 32'h77 || regB !== 32'h66) begin
      errors++; $display("FAIL bypass_next_cycle: regA=%h regB=%h expected 77 66", regA, regB);
    end
  endtask

  task automatic test_midrun_reset();
    step();
    we0 = 1'b1; dest = 5'd5; alu = 32'h1234;
    ld = 1'b1; iss_addr = 5'd5;
    step();
    idle(); iss_addr = 5'd0; chk = 1'b1; rs = 5'd5; rt = 5'd3;
    #2;
    checks++;
    if (regA !== 32'h1234 || stall !== 1'b1 || wr_conflict !== 1'b1) begin
      errors++; $display("FAIL pre_reset: regA=%h stall=%b conflict=%b expected 1234 1 1",
                         regA, stall, wr_conflict);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (regA !== 32'h0 || regB !== 32'h0 || stall !== 1'b0 || wr_conflict !== 1'b0) begin
      errors++; $display("FAIL midrun_reset: regA=%h regB=%h stall=%b conflict=%b expected all 0",
                         regA, regB, stall, wr_conflict);
    end
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (regA !== 32'h0 || stall !== 1'b0 || wr_conflict !== 1'b0) begin
      errors++; $display("FAIL post_reset_r5: regA=%h stall=%b conflict=%b expected 0 0 0",
                         regA, stall, wr_conflict);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_r0();
    test_dual_write();
    test_load_hazard();
    test_set_clear_collision();
    test_bypass();
    test_midrun_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_regfile_sb

`default_nettype wire
